// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer: ALU opcodes,
// sequencer states and the iteration counter sizing helper.
package muldiv_pkg;

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when it does not borrow.
module divu_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned shift-add multiplier / restoring divider beside the execute-stage ALU.
// Define MULDIV_DIV_EN to include the divide path; otherwise only MUL is acted on.
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    import muldiv_pkg::*;

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_d;
    logic [2*WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0]   opnd, opnd_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic               fin_load;
    logic [WIDTH:0]     mul_sum;

    // acc holds {high half, multiplier} for MUL and {remainder, dividend} for DIV.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

`ifdef MULDIV_DIV_EN
    logic             dz_d;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;

    divu_step #(.WIDTH(WIDTH)) u_divu_step (
        .rem_in  (acc[2*WIDTH-1:WIDTH]),
        .bit_in  (acc[WIDTH-1]),
        .divisor (opnd),
        .rem_out (div_rem),
        .q_bit   (div_q)
    );
`endif

    always_comb begin
        state_d  = state;
        acc_d    = acc;
        opnd_d   = opnd;
        cnt_d    = cnt;
        stall    = 1'b0;
        fin_load = 1'b0;
        done     = 1'b0;
`ifdef MULDIV_DIV_EN
        dz_d     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (operation == OP_MUL) begin
                        stall   = 1'b1;
                        state_d = MUL;
                        opnd_d  = operand_a;
                        acc_d   = {{WIDTH{1'b0}}, operand_b};
                        cnt_d   = '0;
                    end
`ifdef MULDIV_DIV_EN
                    else if (operation == OP_DIV) begin
                        stall  = 1'b1;
                        opnd_d = operand_b;
                        cnt_d  = '0;
                        if (operand_b != '0) begin
                            state_d = DIV;
                            acc_d   = {{WIDTH{1'b0}}, operand_a};
                        end else begin
                            state_d  = FIN;
                            acc_d    = {operand_a, {WIDTH{1'b1}}};
                            fin_load = 1'b1;
                            dz_d     = 1'b1;
                        end
                    end
`endif
                end
            end
            MUL: begin
                stall = 1'b1;
                acc_d = {mul_sum, acc[WIDTH-1:1]};
                cnt_d = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_d  = FIN;
                    fin_load = 1'b1;
                end
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                stall = 1'b1;
                acc_d = {div_rem, acc[WIDTH-2:0], div_q};
                cnt_d = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_d  = FIN;
                    fin_load = 1'b1;
                end
            end
`endif
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a completing iteration.
        if (flush) begin
            state_d  = IDLE;
            fin_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            opnd      <= '0;
            cnt       <= '0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            opnd  <= opnd_d;
            cnt   <= cnt_d;
            if (fin_load) begin
                result_lo <= acc_d[WIDTH-1:0];
                result_hi <= acc_d[2*WIDTH-1:WIDTH];
            end
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_by_zero <= 1'b0;
        end else if (fin_load) begin
            div_by_zero <= dz_d;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH=16); divide scenarios depend on MULDIV_DIV_EN.
module tb_muldiv_sequencer;

    localparam int WIDTH = 16;
    localparam logic [3:0] C_MUL = 4'b0010;
    localparam logic [3:0] C_DIV = 4'b0011;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [3:0]       operation;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .operation   (operation),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .stall       (stall),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    // Reference model straight from the arithmetic definition of each operation.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] lo, output logic [15:0] hi, output logic dz,
                         output int lat);
        logic [31:0] prod;
        prod = 32'(a) * 32'(b);
        lo = prod[15:0];
        hi = prod[31:16];
        dz = 1'b0;
        lat = WIDTH + 1;
        if (op == C_DIV) begin
            if (b == 16'd0) begin
                lo = 16'hFFFF;
                hi = a;
                dz = 1'b1;
                lat = 1;
            end else begin
                lo = a / b;
                hi = a % b;
            end
        end
    endtask

    // Issue one request in cycle 0 and watch up to 40 cycles for done.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int flush_cyc, output int done_cyc, output int nstall,
                         output bit moved);
        logic [15:0] lo0, hi0;
        lo0 = result_lo;
        hi0 = result_hi;
        done_cyc = -1;
        nstall = 0;
        moved = 1'b0;
        @(negedge clk);
        start = 1'b1;
        operation = op;
        operand_a = a;
        operand_b = b;
        #1;
        if (stall) nstall++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == flush_cyc);
            #1;
            if (stall) nstall++;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (result_lo !== lo0 || result_hi !== hi0) moved = 1'b1;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        operation = 4'd0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({stall, done, div_by_zero, result_lo, result_hi} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state: got stall=%0b done=%0b dz=%0b lo=%0h hi=%0h expected all 0",
                     stall, done, div_by_zero, result_lo, result_hi);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_mul();
        int dc, ns;
        bit mv;
        do_op(C_MUL, 16'd3, 16'd5, -1, dc, ns, mv);
        total++;
        if (dc != 17) begin bad++; $display("[TB] FAIL mul_latency: got %0d expected 17", dc); end
        total++;
        if (ns != 17) begin bad++; $display("[TB] FAIL mul_stall_cycles: got %0d expected 17", ns); end
        total++;
        if (mv) begin bad++; $display("[TB] FAIL mul_result_hold: got changed expected unchanged"); end
        total++;
        if (result_lo !== 16'd15 || result_hi !== 16'd0) begin
            bad++;
            $display("[TB] FAIL mul_3x5: got %0h:%0h expected 0:f", result_hi, result_lo);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("[TB] FAIL done_pulse_width: got %0b expected 0", done); end
        do_op(C_MUL, 16'hFFFF, 16'hFFFF, -1, dc, ns, mv);
        total++;
        if (result_hi !== 16'hFFFE || result_lo !== 16'h0001 || dc != 17) begin
            bad++;
            $display("[TB] FAIL mul_ffff: got %0h:%0h cyc=%0d expected fffe:1 cyc=17", result_hi, result_lo, dc);
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        int dc, ns;
        bit mv;
        do_op(C_DIV, 16'd100, 16'd7, -1, dc, ns, mv);
        total++;
        if (result_lo !== 16'd14 || result_hi !== 16'd2 || div_by_zero !== 1'b0 || dc != 17) begin
            bad++;
            $display("[TB] FAIL div_100_7: got q=%0d r=%0d dz=%0b cyc=%0d expected q=14 r=2 dz=0 cyc=17",
                     result_lo, result_hi, div_by_zero, dc);
        end
        do_op(C_DIV, 16'd5, 16'd0, -1, dc, ns, mv);
        total++;
        if (dc != 1 || ns != 1) begin
            bad++;
            $display("[TB] FAIL div0_latency: got cyc=%0d stalls=%0d expected cyc=1 stalls=1", dc, ns);
        end
        total++;
        if (result_lo !== 16'hFFFF || result_hi !== 16'd5 || div_by_zero !== 1'b1) begin
            bad++;
            $display("[TB] FAIL div0_result: got q=%0h r=%0h dz=%0b expected q=ffff r=5 dz=1",
                     result_lo, result_hi, div_by_zero);
        end
        do_op(C_MUL, 16'd2, 16'd3, -1, dc, ns, mv);
        total++;
        if (div_by_zero !== 1'b0 || result_lo !== 16'd6) begin
            bad++;
            $display("[TB] FAIL dz_clear_by_mul: got dz=%0b lo=%0d expected dz=0 lo=6", div_by_zero, result_lo);
        end
    endtask
`else
    task automatic test_div_disabled();
        int dc, ns;
        bit mv;
        do_op(C_DIV, 16'd100, 16'd7, -1, dc, ns, mv);
        total++;
        if (dc != -1 || ns != 0) begin
            bad++;
            $display("[TB] FAIL div_ignored: got cyc=%0d stalls=%0d expected cyc=-1 stalls=0", dc, ns);
        end
        do_op(C_DIV, 16'd5, 16'd0, -1, dc, ns, mv);
        total++;
        if (dc != -1 || div_by_zero !== 1'b0) begin
            bad++;
            $display("[TB] FAIL div0_ignored: got cyc=%0d dz=%0b expected cyc=-1 dz=0", dc, div_by_zero);
        end
    endtask
`endif

    task automatic test_flush();
        int dc, ns;
        bit mv;
        do_op(C_MUL, 16'd7, 16'd9, -1, dc, ns, mv);
        do_op(C_MUL, 16'd3, 16'd5, 5, dc, ns, mv);
        total++;
        if (dc != -1) begin bad++; $display("[TB] FAIL flush_no_done: got cyc=%0d expected -1", dc); end
        total++;
        if (ns != 6) begin bad++; $display("[TB] FAIL flush_stall: got %0d expected 6", ns); end
        total++;
        if (mv || result_lo !== 16'd63 || result_hi !== 16'd0) begin
            bad++;
            $display("[TB] FAIL flush_results: got %0h:%0h expected 0:3f", result_hi, result_lo);
        end
        do_op(C_MUL, 16'd11, 16'd13, -1, dc, ns, mv);
        total++;
        if (dc != 17 || result_lo !== 16'd143) begin
            bad++;
            $display("[TB] FAIL after_flush: got cyc=%0d lo=%0d expected cyc=17 lo=143", dc, result_lo);
        end
    endtask

    task automatic test_ignored_op();
        logic [3:0] ops [4] = '{4'b0000, 4'b0001, 4'b0100, 4'b1111};
        int seen;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b1;
            operation = ops[i];
            operand_a = 16'($urandom);
            operand_b = 16'($urandom);
            #1;
            total++;
            if (stall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL ignored_stall op=%0h: got %0b expected 0", ops[i], stall);
            end
            seen = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                if (done) seen++;
            end
            total++;
            if (seen != 0) begin
                bad++;
                $display("[TB] FAIL ignored_done op=%0h: got %0d pulses expected 0", ops[i], seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc, ns, seen;
        bit mv;
        do_op(C_MUL, 16'd21, 16'd2, -1, dc, ns, mv);
        start = 1'b1;
        operation = C_MUL;
        operand_a = 16'd2;
        operand_b = 16'd2;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) seen++;
        end
        total++;
        if (seen != 0 || result_lo !== 16'd42) begin
            bad++;
            $display("[TB] FAIL start_in_fin: got pulses=%0d lo=%0d expected pulses=0 lo=42", seen, result_lo);
        end
    endtask

    task automatic test_random();
        int dc, ns, lat;
        bit mv;
        logic [3:0] op;
        logic [15:0] a, b, elo, ehi;
        logic edz;
        for (int i = 0; i < 24; i++) begin
`ifdef MULDIV_DIV_EN
            op = ($urandom_range(0, 1) == 0) ? C_MUL : C_DIV;
`else
            op = C_MUL;
`endif
            a = 16'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            model(op, a, b, elo, ehi, edz, lat);
            do_op(op, a, b, -1, dc, ns, mv);
            total++;
            if (result_lo !== elo || result_hi !== ehi || div_by_zero !== edz || dc != lat) begin
                bad++;
                $display("[TB] FAIL random op=%0h a=%0h b=%0h: got %0h:%0h dz=%0b cyc=%0d expected %0h:%0h dz=%0b cyc=%0d",
                         op, a, b, result_hi, result_lo, div_by_zero, dc, ehi, elo, edz, lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dc, ns, seen;
        bit mv;
        do_op(C_MUL, 16'd300, 16'd500, -1, dc, ns, mv);
        @(negedge clk);
        start = 1'b1;
`ifdef MULDIV_DIV_EN
        operation = C_DIV;
`else
        operation = C_MUL;
`endif
        operand_a = 16'd1000;
        operand_b = 16'd3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({stall, done, div_by_zero, result_lo, result_hi} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid_op: got stall=%0b done=%0b dz=%0b lo=%0h hi=%0h expected all 0",
                     stall, done, div_by_zero, result_lo, result_hi);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            #1;
            if (done || stall) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("[TB] FAIL reset_mid_idle: got %0d busy cycles expected 0", seen);
        end
        do_op(C_MUL, 16'd3, 16'd5, -1, dc, ns, mv);
        total++;
        if (dc != 17 || result_lo !== 16'd15) begin
            bad++;
            $display("[TB] FAIL after_reset_op: got cyc=%0d lo=%0d expected cyc=17 lo=15", dc, result_lo);
        end
    endtask

    initial begin
        $display("[TB] starting muldiv_sequencer bench");
        test_reset();
        test_mul();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_flush();
        test_ignored_op();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
